// File: rtl/ihex_pkg.sv
// Shared definitions for the Intel-HEX loader: parser states, record types and
// the record start character.
package ihex_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN    = 4'd1,
        ST_ADDRH  = 4'd2,
        ST_ADDRL  = 4'd3,
        ST_TYPE   = 4'd4,
        ST_DATA   = 4'd5,
        ST_CHK    = 4'd6,
        ST_COMMIT = 4'd7,
        ST_RESYNC = 4'd8
    } state_t;

    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;
    localparam logic [7:0] REC_ELA  = 8'h04;
    localparam logic [7:0] COLON    = 8'h3A;

endpackage

// File: rtl/ihex_hex_nibble.sv
// ASCII hex digit decoder: 0-9, A-F, a-f map to a nibble with a valid flag.
module ihex_hex_nibble (
    input  logic [7:0] i_ascii,
    output logic       o_valid,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_valid  = 1'b0;
        o_nibble = '0;
        if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
            o_valid  = 1'b1;
            o_nibble = i_ascii[3:0];
        end else if ((i_ascii >= 8'h41 && i_ascii <= 8'h46) ||
                     (i_ascii >= 8'h61 && i_ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 10
            o_valid  = 1'b1;
            o_nibble = i_ascii[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/ihex_loader.sv
// Intel-HEX record parser: checksums each record, commits data bytes to memory
// only after a good checksum, and answers every record with ACK or NAK.
module ihex_loader
    import ihex_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_LEN  = 16,
    parameter logic [7:0]  ACK_CHAR = 8'h06,
    parameter logic [7:0]  NAK_CHAR = 8'h15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_rdy,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_busy,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_done,
    output logic [7:0]        o_err_cnt,
    output logic [3:0]        o_status
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t            state_q, state_d;
    logic              nib_lo_q, nib_lo_d;
    logic [3:0]        hi_q, hi_d;
    logic [7:0]        sum_q, sum_d, len_q, len_d, type_q, type_d, idx_q, idx_d;
    logic [15:0]       off_q, off_d, ext_q, ext_d;
    logic [7:0]        buf_q [MAX_LEN];
    logic [7:0]        buf_d [MAX_LEN];
    logic              pend_q, pend_d;
    logic [7:0]        pdata_q, pdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [7:0]        err_q, err_d;
    logic              hold_q, hold_d;
    logic [7:0]        hdata_q, hdata_d;

    logic              byte_vld, hex_vld, bad, good;
    logic [7:0]        byte_val, full_byte, sum_new;
    logic [3:0]        hex_nib;
    logic [31:0]       full_addr;

    ihex_hex_nibble u_nib (
        .i_ascii  (byte_val),
        .o_valid  (hex_vld),
        .o_nibble (hex_nib)
    );

    assign full_byte = {hi_q, hex_nib};
    assign sum_new   = sum_q + full_byte;

    always_comb begin
        state_d = state_q;   nib_lo_d = nib_lo_q; hi_d    = hi_q;
        sum_d   = sum_q;     len_d    = len_q;    type_d  = type_q;
        idx_d   = idx_q;     off_d    = off_q;    ext_d   = ext_q;
        buf_d   = buf_q;     pend_d   = pend_q;   pdata_d = pdata_q;
        we_d    = 1'b0;      addr_d   = addr_q;   wdata_d = wdata_q;
        done_d  = done_q;    err_d    = err_q;    hold_d  = hold_q;
        hdata_d = hdata_q;
        bad = 1'b0; good = 1'b0; full_addr = '0;

        // Bytes seen during COMMIT park in the hold register; it drains first afterwards
        byte_vld = 1'b0;
        byte_val = i_rx_data;
        if (state_q == ST_COMMIT) begin
            if (i_rx_rdy) begin
                hold_d  = 1'b1;
                hdata_d = i_rx_data;
            end
        end else if (hold_q) begin
            byte_vld = 1'b1;
            byte_val = hdata_q;
            hold_d   = i_rx_rdy;
            hdata_d  = i_rx_data;
        end else begin
            byte_vld = i_rx_rdy;
        end

        if (pend_q && !i_tx_busy) pend_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESYNC: begin
                if (byte_vld && byte_val == COLON) begin
                    state_d = ST_LEN; sum_d = '0; idx_d = '0; nib_lo_d = 1'b0;
                end
            end
            ST_COMMIT: begin
                if (idx_q < len_q) begin
                    full_addr = {ext_q, off_q + {8'h00, idx_q}};
                    we_d      = 1'b1;
                    addr_d    = full_addr[ADDR_W-1:0];
                    wdata_d   = buf_q[idx_q[IDX_W-1:0]];
                    idx_d     = idx_q + 8'd1;
                end else begin
                    good    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (byte_vld) begin
                    if (byte_val == COLON) begin
                        bad = 1'b1;
                        state_d = ST_LEN; sum_d = '0; idx_d = '0; nib_lo_d = 1'b0;
                    end else if (!hex_vld) begin
                        bad = 1'b1;
                        state_d = ST_RESYNC;
                    end else if (!nib_lo_q) begin
                        hi_d     = hex_nib;
                        nib_lo_d = 1'b1;
                    end else begin
                        nib_lo_d = 1'b0;
                        sum_d    = sum_new;
                        case (state_q)
                            ST_LEN: begin
                                if (32'(full_byte) > MAX_LEN) begin
                                    bad = 1'b1; state_d = ST_RESYNC;
                                end else begin
                                    len_d = full_byte; state_d = ST_ADDRH;
                                end
                            end
                            ST_ADDRH: begin off_d[15:8] = full_byte; state_d = ST_ADDRL; end
                            ST_ADDRL: begin off_d[7:0]  = full_byte; state_d = ST_TYPE;  end
                            ST_TYPE: begin
                                type_d = full_byte;
                                if (full_byte == REC_ELA && len_q != 8'd2) begin
                                    bad = 1'b1; state_d = ST_RESYNC;
                                end else begin
                                    state_d = (len_q == 8'd0) ? ST_CHK : ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                buf_d[idx_q[IDX_W-1:0]] = full_byte;
                                idx_d = idx_q + 8'd1;
                                if (idx_q + 8'd1 == len_q) state_d = ST_CHK;
                            end
                            ST_CHK: begin
                                state_d = ST_IDLE;
                                if (sum_new != 8'h00) begin
                                    bad = 1'b1; state_d = ST_RESYNC;
                                end else if (type_q == REC_DATA && len_q != 8'd0) begin
                                    // First write issues here so writes land on T+1..T+LEN
                                    full_addr = {ext_q, off_q};
                                    we_d      = 1'b1;
                                    addr_d    = full_addr[ADDR_W-1:0];
                                    wdata_d   = buf_q[0];
                                    idx_d     = 8'd1;
                                    state_d   = ST_COMMIT;
                                end else begin
                                    good = 1'b1;
                                    if (type_q == REC_EOF) done_d = 1'b1;
                                    if (type_q == REC_ELA) ext_d = {buf_q[0], buf_q[1]};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (bad) begin
            pend_d  = 1'b1;
            pdata_d = NAK_CHAR;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else if (good) begin
            pend_d  = 1'b1;
            pdata_d = ACK_CHAR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE; nib_lo_q <= 1'b0; hi_q    <= '0;
            sum_q   <= '0;      len_q    <= '0;   type_q  <= '0;
            idx_q   <= '0;      off_q    <= '0;   ext_q   <= '0;
            buf_q   <= '{default: '0};
            pend_q  <= 1'b0;    pdata_q  <= '0;   we_q    <= 1'b0;
            addr_q  <= '0;      wdata_q  <= '0;   done_q  <= 1'b0;
            err_q   <= '0;      hold_q   <= 1'b0; hdata_q <= '0;
        end else begin
            state_q <= state_d; nib_lo_q <= nib_lo_d; hi_q    <= hi_d;
            sum_q   <= sum_d;   len_q    <= len_d;    type_q  <= type_d;
            idx_q   <= idx_d;   off_q    <= off_d;    ext_q   <= ext_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;  pdata_q  <= pdata_d;  we_q    <= we_d;
            addr_q  <= addr_d;  wdata_q  <= wdata_d;  done_q  <= done_d;
            err_q   <= err_d;   hold_q   <= hold_d;   hdata_q <= hdata_d;
        end
    end

    assign o_tx_start  = pend_q && !i_tx_busy;
    assign o_tx_data   = pdata_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_done      = done_q;
    assign o_err_cnt   = err_q;
    assign o_status    = state_q;

endmodule

// File: doc/ihex_loader.md
Name: ihex_loader

Overview:
- Sits between uart_rx/uart_tx and a byte-wide program/data memory in the UART Intel-HEX loader.
- Consumes the received ASCII byte stream and parses Intel-HEX records.
- Checks each record's checksum and commits data bytes to memory only after the checksum passes.
- Answers every record with an ACK or NAK byte through uart_tx, and exposes a status nibble for the seven-segment display.

Parameters:
- ADDR_W, 32, memory address width; the full {ext,offset} address is truncated to the low ADDR_W bits.
- MAX_LEN, 16, record buffer depth in bytes; any record with LEN>MAX_LEN is an error.
- ACK_CHAR, 8'h06, response byte for a good record.
- NAK_CHAR, 8'h15, response byte for a bad record.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_rdy  in  1  one-cycle strobe from uart_rx; i_rx_data is valid in that cycle.
- i_rx_data  in  8  received ASCII byte.
- i_tx_busy  in  1  uart_tx busy.
- o_tx_start  out  1  one-cycle load strobe to uart_tx.
- o_tx_data  out  8  response byte; valid while o_tx_start is high.
- o_mem_we  out  1  memory write strobe.
- o_mem_addr  out  ADDR_W  write address.
- o_mem_wdata  out  8  write data.
- o_done  out  1  sticky; an EOF record has been accepted.
- o_err_cnt  out  8  count of bad records; saturates at 255.
- o_status  out  4  current state code, driven to the seven-segment display.

Behaviour:
- Reset values: all outputs 0, ext_addr=0, state=IDLE, no pending response, rx hold register empty.
- States (o_status code): IDLE=0, LEN=1, ADDRH=2, ADDRL=3, TYPE=4, DATA=5, CHK=6, COMMIT=7, RESYNC=8.
- IDLE: ignores every byte except ':' (8'h3A). On ':' -> LEN; clear the running checksum and the data index.
- Field states: each field byte is two ASCII hex characters, high nibble first. A nibble toggle selects which half is being received.
  - Accepted characters: 0-9, A-F, a-f.
  - The completed byte is added to the running 8-bit checksum.
- Field sequence: LEN -> ADDRH -> ADDRL -> TYPE -> DATA (repeated LEN times; skipped if LEN=0) -> CHK.
- DATA bytes are stored in buffer[index].
- Errors. Any of the following queues a NAK, increments o_err_cnt, writes nothing and moves to RESYNC:
  - a non-hex character inside a field;
  - LEN>MAX_LEN, detected when the LEN byte completes;
  - a type-04 record with LEN!=2, detected at TYPE;
  - checksum!=0 after the CHK byte.
- RESYNC: waits for ':' and then behaves as IDLE on ':'.
- ':' received inside any field state: the current record is aborted and counted as an error (NAK). Parsing restarts at LEN in the next cycle.
- Good checksum (sum of all bytes including CHK == 8'h00), actions by TYPE:
  - 00: go to COMMIT. Write buffer[i] for i=0..LEN-1, one byte per cycle, at {ext_addr, (offset+i) mod 2^16} truncated to ADDR_W. ext_addr does not carry. After the last write, queue ACK and return to IDLE.
  - 01: set o_done (held until reset), queue ACK, go to IDLE.
  - 04: ext_addr <= {data0,data1}, queue ACK, go to IDLE.
  - any other type: queue ACK, go to IDLE, no other action.
- Latency: let T be the cycle in which the final CHK character strobe arrives.
  - Writes occur at T+1..T+LEN.
  - The response is queued at T+LEN+1 (T+1 for non-data records).
- Response handshake:
  - One pending-response register.
  - o_tx_start pulses for one cycle in the first cycle where a response is pending and i_tx_busy=0; the pending flag clears in that cycle.
  - A new response queued while one is still pending overwrites it (newest wins).
- Reception during COMMIT: a one-entry hold register captures any byte strobed in. It is processed in the cycle after COMMIT ends. A second byte arriving in COMMIT overwrites the first.
- Reset mid-record or mid-COMMIT: immediate return to reset values; partial writes already performed stand.

Decomposition:
- ihex_pkg holds:
  - the state enum with fixed 4-bit encodings;
  - record type constants REC_DATA=8'h00, REC_EOF=8'h01, REC_ELA=8'h04;
  - the COLON constant.
- One combinational sub-module, ihex_hex_nibble: ASCII in -> {valid, nibble[3:0]}.

Test Plan:
- ":02000000ABCD86" -> two consecutive we cycles, addr 0=AB and 1=CD; one o_tx_start with data 06; err_cnt 0.
- ":020000040001F9" then ":02FFFF001122CD" -> writes 0x0001FFFF=11 and 0x00010000=22 (offset wraps, ext does not); two ACKs.
- ":02000000ABCD87" (bad checksum) -> no we; NAK 15; err_cnt=1; the following ":00000001FF" sets o_done and sends ACK.
- ":02G0…" followed by junk, then ":00000001FF" -> NAK at 'G'; junk ignored in RESYNC (status 8); EOF accepted.
- ":11…" (LEN=17) -> NAK when LEN completes; no writes. ':' injected mid-DATA -> err_cnt increments and the new record parses correctly.
- Hold i_tx_busy=1 across two records -> only the second response is sent, once busy drops. Assert i_rst_n=0 mid-COMMIT -> all outputs 0 in the same cycle.
